// File: rtl/dot_product_mac.sv
// Sequential multiply-accumulate: takes LEN unsigned operand pairs over valid/ready
// and presents their dot product on a held valid/ready result port.
module dot_product_mac #(
   parameter int DATA_W = 8,
   parameter int LEN    = 4,
   parameter int ACC_W  = 2*DATA_W + $clog2(LEN)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [ACC_W-1:0]  result,
   output logic              out_valid,
   input  logic              out_ready
);

   localparam int                CNT_W    = (LEN > 1) ? $clog2(LEN) : 1;
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(LEN - 1);

   typedef enum logic {
      ST_ACCUM = 1'b0,
      ST_DONE  = 1'b1
   } state_t;

   state_t               r_state;
   logic [CNT_W-1:0]     r_cnt;
   logic [ACC_W-1:0]     r_acc;
   logic [ACC_W-1:0]     r_result;

   logic [2*DATA_W-1:0]  w_prod;
   logic [ACC_W-1:0]     w_sum;
   logic                 w_accept;

   // Operands are widened before the multiply so the full product is kept.
   assign w_prod   = {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, b};
   assign w_sum    = r_acc + ACC_W'(w_prod);
   assign w_accept = in_valid && (r_state == ST_ACCUM);

   // Handshake outputs depend on the state register alone.
   assign in_ready  = (r_state == ST_ACCUM);
   assign out_valid = (r_state == ST_DONE);
   assign result    = r_result;

   // NOTE: all state uses non-blocking assignments so every register samples
   // pre-edge values; the reset branch clears result too, as it is visible.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= ST_ACCUM;
         r_cnt    <= '0;
         r_acc    <= '0;
         r_result <= '0;
      end else begin
         case (r_state)
            ST_ACCUM: begin
               if (w_accept) begin
                  if (r_cnt == CNT_LAST) begin
                     r_result <= w_sum;
                     r_acc    <= '0;
                     r_cnt    <= '0;
                     r_state  <= ST_DONE;
                  end else begin
                     r_acc    <= w_sum;
                     r_cnt    <= r_cnt + 1'b1;
                  end
               end
            end
            ST_DONE: begin
               if (out_ready) begin
                  r_state <= ST_ACCUM;
               end
            end
            default: r_state <= ST_ACCUM;
         endcase
      end
   end

endmodule

// File: tb/tb_dot_product_mac.sv
// Directed bench for dot_product_mac at default parameters (DATA_W=8, LEN=4).
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_dot_product_mac;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  a;
   logic [7:0]  b;
   logic        in_valid;
   logic        in_ready;
   logic [17:0] result;
   logic        out_valid;
   logic        out_ready;

   int total = 0;
   int bad   = 0;

   dot_product_mac dut (
      .clk       (clk),
      .rst       (rst),
      .a         (a),
      .b         (b),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .result    (result),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Presents one pair and returns just after the edge that accepts it.
   task automatic send(input logic [7:0] xa, input logic [7:0] xb);
      int waited;
      waited   = 0;
      a        = xa;
      b        = xb;
      in_valid = 1'b1;
      while (in_ready !== 1'b1 && waited < 20) begin
         step();
         waited++;
      end
      if (waited >= 20) begin
         total++;
         bad++;
         $display("FAIL send_timeout: in_ready got=%0b required=1", in_ready);
      end
      step();
      in_valid = 1'b0;
      a        = 8'($urandom);
      b        = 8'($urandom);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      for (int i = 0; i < 2; i++) begin
         a         = 8'($urandom);
         b         = 8'($urandom);
         in_valid  = 1'($urandom);
         out_ready = 1'($urandom);
         step();
         total++;
         if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid cyc%0d: got=%0b required=0", i, out_valid); end
         total++;
         if (result !== 18'd0) begin bad++; $display("FAIL reset_result cyc%0d: got=%0d required=0", i, result); end
         total++;
         if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready cyc%0d: got=%0b required=1", i, in_ready); end
      end
      rst       = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
   endtask

   task automatic test_basic();
      out_ready = 1'b1;
      send(8'd1, 8'd5);
      send(8'd2, 8'd6);
      send(8'd3, 8'd7);
      total++;
      if (out_valid !== 1'b0) begin bad++; $display("FAIL basic_early_valid: got=%0b required=0", out_valid); end
      send(8'd4, 8'd8);
      total++;
      if (out_valid !== 1'b1) begin bad++; $display("FAIL basic_out_valid: got=%0b required=1", out_valid); end
      total++;
      if (result !== 18'd70) begin bad++; $display("FAIL basic_result: got=%0d required=70", result); end
      total++;
      if (in_ready !== 1'b0) begin bad++; $display("FAIL basic_in_ready_done: got=%0b required=0", in_ready); end
      step();
      total++;
      if (out_valid !== 1'b0) begin bad++; $display("FAIL basic_valid_one_cycle: got=%0b required=0", out_valid); end
      total++;
      if (in_ready !== 1'b1) begin bad++; $display("FAIL basic_in_ready_after: got=%0b required=1", in_ready); end
      total++;
      if (result !== 18'd70) begin bad++; $display("FAIL basic_result_kept: got=%0d required=70", result); end
   endtask

   task automatic test_max();
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) send(8'd255, 8'd255);
      total++;
      if (out_valid !== 1'b1) begin bad++; $display("FAIL max_out_valid: got=%0b required=1", out_valid); end
      total++;
      if (result !== 18'd260100) begin bad++; $display("FAIL max_result: got=%0d required=260100", result); end
      step();
      for (int i = 0; i < 4; i++) send(8'd0, 8'd0);
      total++;
      if (out_valid !== 1'b1) begin bad++; $display("FAIL zero_out_valid: got=%0b required=1", out_valid); end
      total++;
      if (result !== 18'd0) begin bad++; $display("FAIL zero_result: got=%0d required=0", result); end
      step();
   endtask

   task automatic test_bubbles();
      logic [7:0] va [4];
      logic [7:0] vb [4];
      va = '{8'd1, 8'd2, 8'd3, 8'd4};
      vb = '{8'd5, 8'd6, 8'd7, 8'd8};
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         send(va[i], vb[i]);
         if (i < 3) begin
            for (int g = 0; g <= i; g++) begin
               a = 8'($urandom);
               b = 8'($urandom);
               step();
               total++;
               if (out_valid !== 1'b0) begin bad++; $display("FAIL bubble_early_valid el%0d: got=%0b required=0", i, out_valid); end
            end
         end
      end
      total++;
      if (out_valid !== 1'b1) begin bad++; $display("FAIL bubble_out_valid: got=%0b required=1", out_valid); end
      total++;
      if (result !== 18'd70) begin bad++; $display("FAIL bubble_result: got=%0d required=70", result); end
      step();
   endtask

   task automatic test_backpressure();
      out_ready = 1'b0;
      send(8'd1, 8'd5);
      send(8'd2, 8'd6);
      send(8'd3, 8'd7);
      send(8'd4, 8'd8);
      in_valid = 1'b1;
      a        = 8'd9;
      b        = 8'd9;
      for (int i = 0; i < 5; i++) begin
         total++;
         if (out_valid !== 1'b1) begin bad++; $display("FAIL bp_out_valid cyc%0d: got=%0b required=1", i, out_valid); end
         total++;
         if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready cyc%0d: got=%0b required=0", i, in_ready); end
         total++;
         if (result !== 18'd70) begin bad++; $display("FAIL bp_result cyc%0d: got=%0d required=70", i, result); end
         step();
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      step();
      total++;
      if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_release_in_ready: got=%0b required=1", in_ready); end
      for (int i = 0; i < 4; i++) send(8'd1, 8'd2);
      total++;
      if (out_valid !== 1'b1) begin bad++; $display("FAIL bp_next_out_valid: got=%0b required=1", out_valid); end
      total++;
      if (result !== 18'd8) begin bad++; $display("FAIL bp_next_result: got=%0d required=8", result); end
      step();
   endtask

   // Reset raised mid-cycle must wait for the clock edge before clearing anything.
   task automatic test_reset_sync();
      out_ready = 1'b0;
      send(8'd1, 8'd5);
      send(8'd2, 8'd6);
      send(8'd3, 8'd7);
      send(8'd4, 8'd8);
      rst = 1'b1;
      #2;
      total++;
      if (out_valid !== 1'b1) begin bad++; $display("FAIL rst_sync_before_edge_valid: got=%0b required=1", out_valid); end
      total++;
      if (result !== 18'd70) begin bad++; $display("FAIL rst_sync_before_edge_result: got=%0d required=70", result); end
      step();
      total++;
      if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_sync_after_edge_valid: got=%0b required=0", out_valid); end
      total++;
      if (result !== 18'd0) begin bad++; $display("FAIL rst_sync_after_edge_result: got=%0d required=0", result); end
      total++;
      if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_sync_after_edge_in_ready: got=%0b required=1", in_ready); end
      rst       = 1'b0;
      out_ready = 1'b1;
   endtask

   task automatic test_reset_mid();
      out_ready = 1'b1;
      send(8'd10, 8'd10);
      send(8'd10, 8'd10);
      // Reset wins over an element offered in the same cycle.
      rst      = 1'b1;
      in_valid = 1'b1;
      a        = 8'd10;
      b        = 8'd10;
      step();
      rst      = 1'b0;
      in_valid = 1'b0;
      total++;
      if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_rst_out_valid: got=%0b required=0", out_valid); end
      total++;
      if (in_ready !== 1'b1) begin bad++; $display("FAIL mid_rst_in_ready: got=%0b required=1", in_ready); end
      send(8'd1, 8'd5);
      send(8'd2, 8'd6);
      send(8'd3, 8'd7);
      total++;
      if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_rst_spurious_valid: got=%0b required=0", out_valid); end
      send(8'd4, 8'd8);
      total++;
      if (out_valid !== 1'b1) begin bad++; $display("FAIL mid_rst_final_valid: got=%0b required=1", out_valid); end
      total++;
      if (result !== 18'd70) begin bad++; $display("FAIL mid_rst_result: got=%0d required=70", result); end
      step();
   endtask

   initial begin
      rst       = 1'b1;
      a         = 8'd0;
      b         = 8'd0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      test_reset();
      test_basic();
      test_max();
      test_bubbles();
      test_backpressure();
      test_reset_sync();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
